pcie_axi_mem_responder: RTL and testbench
=========================================

Name: pcie_axi_mem_responder

Overview:
AXI4 memory responder that terminates the PCIe core's AXI master port (m_axi_*). It sinks inbound TLP-derived writes into an internal beat-wide RAM and returns read data, with independent write and read FSMs. It serves as the endpoint target model in system sims and as the BAR-backed scratch memory on FPGA builds.

Parameters:
DATA_WIDTH, 256, beat width in bits; byte lanes = DATA_WIDTH/8
ID_WIDTH, 6, AXI ID width
ADDR_WIDTH, 64, AXI address width
MEM_DEPTH_LG2, 6, log2 of RAM depth in beats (default 64 beats = 2 KB)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awaddr  in  ADDR_WIDTH  write byte address
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  must be log2(DATA_WIDTH/8)
s_axi_awburst  in  2  FIXED/INCR/WRAP
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_bid  out  ID_WIDTH  echoed awid
s_axi_bresp  out  2  write response
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_arid  in  ID_WIDTH  read ID
s_axi_araddr  in  ADDR_WIDTH  read byte address
s_axi_arlen  in  8  beats-1
s_axi_arsize  in  3  must be log2(DATA_WIDTH/8)
s_axi_arburst  in  2  FIXED/INCR/WRAP
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
s_axi_rid  out  ID_WIDTH  echoed arid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat

Behaviour:
- Clocking/reset: single clock clk; reset rst_n is asynchronous, active-low. All outputs 0 while rst_n=0; RAM contents not reset. awready/arready rise the first clk edge after rst_n deasserts. Reset mid-burst aborts both FSMs to IDLE and drops any pending B/R.
- Beat index = addr[MEM_DEPTH_LG2+4:5]. A request is out of range when any addr bit >= MEM_DEPTH_LG2+5 is set. Next index: FIXED holds; INCR +1 modulo depth; WRAP wraps within an aligned (len+1)-beat window, where len+1 must be 2/4/8/16. Any other WRAP length, burst=2'b11, or a size not equal to 5 is illegal.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch id/index/len/burst and an error code, then go to W_DATA. Error code: DECERR=2'b11 for out of range (takes priority), SLVERR=2'b10 for illegal, else OKAY.
  - W_DATA: wready=1, awready=0. Each W handshake writes the enabled bytes of wdata, unless the error code is non-zero. Beat counter runs 0..len.
  - Leave W_DATA on the beat where counter==len, or on an earlier wlast. Either way go to W_RESP, bvalid=1.
  - bresp is SLVERR if wlast did not coincide with counter==len. An early wlast ends the burst at that beat. A missing wlast on beat len still ends the burst.
  - W_RESP: bvalid/bid/bresp held until bready, then W_IDLE. awready reasserts the next cycle. Minimum 3 cycles per single-beat write.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On AR handshake, latch id/len/burst/error. rdata register loads the RAM at the start index (zeros if error). Enter R_DATA; rvalid=1 the next cycle (1-cycle AR-to-R latency).
  - R_DATA: rvalid, rid, rdata, rresp and rlast (counter==len) are held stable while rready=0.
  - On each handshake, the rdata register loads the next index. After the rlast handshake, return to R_IDLE with rvalid=0 the same edge.
  - rresp carries the latched error code on every beat.
- Simultaneous read and write to the same beat in one cycle: the read register captures the old data (read-before-write). Write and read FSMs run fully concurrently.

Optional Feature:
PCIE_AXI_RESP_BACKPRESSURE_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle. awready, wready and arready are each ANDed with a distinct LFSR bit (bits 0, 5, 10). This exercises core-side stalls. No valid/response timing changes.
- Undefined: no LFSR logic; readies follow the FSMs only.

Test Plan:
- Single write: AW addr 0x40, len 0, INCR, wdata 0xA5 pattern, wstrb all 1s -> bresp=OKAY, bid echoed. Then AR addr 0x40 -> rdata pattern, rlast=1, rresp=OKAY, rvalid one cycle after the AR handshake.
- 4-beat INCR write at 0x80 with beat-1 wstrb=32'h0000FFFF -> readback shows only the low 16 bytes of beat 1 updated, others intact.
- WRAP: len 3 at addr 0x60 -> beat index sequence 3,0,1,2. Readback matches. A WRAP of len 2 gives SLVERR with RAM untouched.
- Out of range: awaddr 0x800 with MEM_DEPTH_LG2=6 -> bresp=DECERR, no RAM change. Read gives rresp=DECERR with rdata=0 on all beats.
- Backpressure/protocol: hold rready=0 for 5 cycles mid-burst -> R signals stable. An early wlast on beat 1 of len 3 -> bresp=SLVERR, FSM returns to IDLE.
- rst_n asserted during R_DATA beat 2 of 8 -> rvalid=0 immediately. After release, arready=1 and a new read completes correctly.

Source files
------------

// File: rtl/pcie_axi_mem_responder_if.sv
// AXI4 slave-side bundle between the PCIe core's m_axi master port and the memory responder.
interface pcie_axi_mem_responder_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ID_WIDTH   = 6,
  parameter int unsigned ADDR_WIDTH = 64
);
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [ID_WIDTH-1:0]     s_axi_awid;
  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [7:0]              s_axi_awlen;
  logic [2:0]              s_axi_awsize;
  logic [1:0]              s_axi_awburst;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wlast;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [ID_WIDTH-1:0]     s_axi_bid;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [ID_WIDTH-1:0]     s_axi_arid;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic [7:0]              s_axi_arlen;
  logic [2:0]              s_axi_arsize;
  logic [1:0]              s_axi_arburst;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;
  logic [ID_WIDTH-1:0]     s_axi_rid;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rlast;

  modport master (
    output s_axi_awvalid, s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
    output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_bready,
    output s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
    output s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bid, s_axi_bresp,
    input  s_axi_arready, s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast
  );

  modport slave (
    input  s_axi_awvalid, s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
    input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_bready,
    input  s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
    input  s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bid, s_axi_bresp,
    output s_axi_arready, s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast
  );
endinterface

// File: rtl/pcie_axi_mem_responder.sv
// AXI4 memory responder: beat-wide RAM behind independent write and read FSMs.
// Optional PCIE_AXI_RESP_BACKPRESSURE_EN gates the readies with an LFSR to create stalls.
module pcie_axi_mem_responder #(
  parameter int unsigned DATA_WIDTH    = 256,
  parameter int unsigned ID_WIDTH      = 6,
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned MEM_DEPTH_LG2 = 6
) (
  input logic clk,
  input logic rst_n,
  pcie_axi_mem_responder_if.slave bus
);
  localparam int unsigned LANES    = DATA_WIDTH / 8;
  localparam int unsigned LANE_LG2 = $clog2(LANES);
  localparam int unsigned DEPTH    = 1 << MEM_DEPTH_LG2;
  localparam int unsigned IDX_LO   = LANE_LG2;
  localparam int unsigned IDX_HI   = MEM_DEPTH_LG2 + LANE_LG2 - 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef logic [MEM_DEPTH_LG2-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // WRAP keeps the upper index bits and counts within the (len+1)-beat window.
  function automatic idx_t next_idx(input idx_t idx, input logic [1:0] burst, input logic [7:0] len);
    idx_t mask;
    mask = MEM_DEPTH_LG2'(len);
    case (burst)
      BURST_FIXED: next_idx = idx;
      BURST_WRAP:  next_idx = (idx & ~mask) | ((idx + MEM_DEPTH_LG2'(1)) & mask);
      default:     next_idx = idx + MEM_DEPTH_LG2'(1);
    endcase
  endfunction

  function automatic logic [1:0] req_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    if ((addr >> (IDX_HI + 1)) != '0)
      req_err = RESP_DECERR;
    else if (size != 3'(LANE_LG2) || burst == BURST_RSVD || (burst == BURST_WRAP && !wrap_ok))
      req_err = RESP_SLVERR;
    else
      req_err = RESP_OKAY;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t w_state_q, w_state_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0] bresp_q, bresp_d, w_err_q, w_err_d, w_burst_q, w_burst_d;
  logic [7:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  idx_t w_idx_q, w_idx_d;
  logic mem_we;

  r_state_t r_state_q, r_state_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [1:0] rresp_q, rresp_d, r_err_q, r_err_d, r_burst_q, r_burst_d;
  logic [7:0] r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  idx_t r_idx_q, r_idx_d, r_nidx;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [2:0] bp;
  logic aw_hs, w_hs, ar_hs;
  logic [1:0] aw_err, ar_err;

`ifdef PCIE_AXI_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign bp = {lfsr_q[10], lfsr_q[5], lfsr_q[0]};
`else
  assign bp = 3'b111;
`endif

  assign bus.s_axi_awready = awready_q & bp[0];
  assign bus.s_axi_wready  = wready_q & bp[1];
  assign bus.s_axi_arready = arready_q & bp[2];
  assign bus.s_axi_bvalid  = bvalid_q;
  assign bus.s_axi_bid     = bid_q;
  assign bus.s_axi_bresp   = bresp_q;
  assign bus.s_axi_rvalid  = rvalid_q;
  assign bus.s_axi_rid     = rid_q;
  assign bus.s_axi_rdata   = rdata_q;
  assign bus.s_axi_rresp   = rresp_q;
  assign bus.s_axi_rlast   = rlast_q;

  assign aw_hs  = bus.s_axi_awvalid & bus.s_axi_awready;
  assign w_hs   = bus.s_axi_wvalid & bus.s_axi_wready;
  assign ar_hs  = bus.s_axi_arvalid & bus.s_axi_arready;
  assign aw_err = req_err(bus.s_axi_awaddr, bus.s_axi_awlen, bus.s_axi_awsize, bus.s_axi_awburst);
  assign ar_err = req_err(bus.s_axi_araddr, bus.s_axi_arlen, bus.s_axi_arsize, bus.s_axi_arburst);

  // RAM is not reset; byte-lane writes
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(LANES); b++)
        if (bus.s_axi_wstrb[b]) mem[w_idx_q][b*8 +: 8] <= bus.s_axi_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE; awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0;
      bid_q <= '0; bresp_q <= '0; w_err_q <= '0; w_burst_q <= '0;
      w_len_q <= '0; w_cnt_q <= '0; w_idx_q <= '0;
    end else begin
      w_state_q <= w_state_d; awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
      bid_q <= bid_d; bresp_q <= bresp_d; w_err_q <= w_err_d; w_burst_q <= w_burst_d;
      w_len_q <= w_len_d; w_cnt_q <= w_cnt_d; w_idx_q <= w_idx_d;
    end
  end

  // Write FSM: a burst ends on counter==len or an earlier wlast; a mismatch yields SLVERR.
  always_comb begin
    w_state_d = w_state_q; awready_d = awready_q; wready_d = wready_q; bvalid_d = bvalid_q;
    bid_d = bid_q; bresp_d = bresp_q; w_err_d = w_err_q; w_burst_d = w_burst_q;
    w_len_d = w_len_q; w_cnt_d = w_cnt_q; w_idx_d = w_idx_q; mem_we = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          awready_d = 1'b0; wready_d = 1'b1;
          bid_d = bus.s_axi_awid; w_idx_d = bus.s_axi_awaddr[IDX_HI:IDX_LO];
          w_len_d = bus.s_axi_awlen; w_burst_d = bus.s_axi_awburst;
          w_err_d = aw_err; w_cnt_d = '0; w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          mem_we = (w_err_q == RESP_OKAY);
          if (w_cnt_q == w_len_q || bus.s_axi_wlast) begin
            wready_d = 1'b0; bvalid_d = 1'b1; w_state_d = W_RESP;
            if (w_err_q != RESP_OKAY) bresp_d = w_err_q;
            else if (w_cnt_q == w_len_q && bus.s_axi_wlast) bresp_d = RESP_OKAY;
            else bresp_d = RESP_SLVERR;
          end else begin
            w_cnt_d = w_cnt_q + 8'd1;
            w_idx_d = next_idx(w_idx_q, w_burst_q, w_len_q);
          end
        end
      end
      W_RESP: begin
        if (bus.s_axi_bready) begin
          bvalid_d = 1'b0; awready_d = 1'b1; w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE; arready_q <= 1'b0; rvalid_q <= 1'b0; rlast_q <= 1'b0;
      rid_q <= '0; rresp_q <= '0; r_err_q <= '0; r_burst_q <= '0;
      r_len_q <= '0; r_cnt_q <= '0; r_idx_q <= '0; rdata_q <= '0;
    end else begin
      r_state_q <= r_state_d; arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
      rid_q <= rid_d; rresp_q <= rresp_d; r_err_q <= r_err_d; r_burst_q <= r_burst_d;
      r_len_q <= r_len_d; r_cnt_q <= r_cnt_d; r_idx_q <= r_idx_d; rdata_q <= rdata_d;
    end
  end

  assign r_nidx = next_idx(r_idx_q, r_burst_q, r_len_q);

  // Read FSM: rdata register is preloaded so each beat is ready one cycle after its predecessor.
  always_comb begin
    r_state_d = r_state_q; arready_d = arready_q; rvalid_d = rvalid_q; rlast_d = rlast_q;
    rid_d = rid_q; rresp_d = rresp_q; r_err_d = r_err_q; r_burst_d = r_burst_q;
    r_len_d = r_len_q; r_cnt_d = r_cnt_q; r_idx_d = r_idx_q; rdata_d = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0; rvalid_d = 1'b1;
          rid_d = bus.s_axi_arid; r_idx_d = bus.s_axi_araddr[IDX_HI:IDX_LO];
          r_len_d = bus.s_axi_arlen; r_burst_d = bus.s_axi_arburst;
          r_err_d = ar_err; rresp_d = ar_err; r_cnt_d = '0;
          rlast_d = (bus.s_axi_arlen == 8'd0);
          rdata_d = (ar_err != RESP_OKAY) ? '0 : mem[bus.s_axi_araddr[IDX_HI:IDX_LO]];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (bus.s_axi_rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0; rlast_d = 1'b0; arready_d = 1'b1; r_state_d = R_IDLE;
          end else begin
            r_cnt_d = r_cnt_q + 8'd1;
            r_idx_d = r_nidx;
            rlast_d = (r_cnt_d == r_len_q);
            rdata_d = (r_err_q != RESP_OKAY) ? '0 : mem[r_nidx];
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end
endmodule

// File: tb/tb_pcie_axi_mem_responder.sv
// Scoreboard bench for pcie_axi_mem_responder: directed and random bursts against an array model.
module tb_pcie_axi_mem_responder;
  typedef struct packed { logic [5:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [5:0] id; logic [255:0] data; logic [1:0] resp; logic last; } r_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int rready_mode = 0;
  b_exp_t b_q[$];
  r_exp_t r_q[$];
  logic [255:0] mdl [64];

  pcie_axi_mem_responder_if #(.DATA_WIDTH(256), .ID_WIDTH(6), .ADDR_WIDTH(64)) bus ();
  pcie_axi_mem_responder #(.DATA_WIDTH(256), .ID_WIDTH(6), .ADDR_WIDTH(64), .MEM_DEPTH_LG2(6))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [1:0] model_err(input logic [63:0] addr, input int len,
                                           input logic [1:0] burst, input logic [2:0] size);
    if (addr >= 64'd2048) return 2'b11;
    if (size != 3'd5 || burst == 2'b11) return 2'b10;
    if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int beat_idx(input int start, input int len, input logic [1:0] burst, input int i);
    int w;
    int base;
    w = len + 1;
    if (burst == 2'b00) return start;
    if (burst == 2'b10) begin
      base = (start / w) * w;
      return base + ((start - base + i) % w);
    end
    return (start + i) % 64;
  endfunction

  // Handshake only resolves on a clock edge where ready was seen high at the preceding negedge.
  task automatic wait_hs(input int ch, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      case (ch)
        0: ok = bus.s_axi_awready;
        1: ok = bus.s_axi_wready;
        default: ok = bus.s_axi_arready;
      endcase
      if (ok) break;
    end
    if (!ok) fail_now($sformatf("ready_timeout ch=%0d", ch));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (b_q.size() == 0 && r_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      fail_now($sformatf("drain_timeout b=%0d r=%0d", b_q.size(), r_q.size()));
      b_q.delete();
      r_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] id, input logic [63:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input int last_at,
                          input bit rnd_strb, input logic [31:0] strb1, input bit pat);
    logic [1:0] err;
    logic [255:0] d;
    logic [31:0] s;
    int start;
    int nbeats;
    int idx;
    bit ok;
    err = model_err(addr, len, burst, size);
    start = int'(addr[10:5]);
    nbeats = ((last_at < len) ? last_at : len) + 1;
    b_q.push_back('{id: id, resp: (err != 2'b00) ? err : ((last_at == len) ? 2'b00 : 2'b10)});
    bus.s_axi_awid = id; bus.s_axi_awaddr = addr; bus.s_axi_awlen = 8'(len);
    bus.s_axi_awsize = size; bus.s_axi_awburst = burst; bus.s_axi_awvalid = 1'b1;
    wait_hs(0, ok);
    bus.s_axi_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      d = pat ? {32{8'hA5}} : rand256();
      s = (i == 1) ? strb1 : (rnd_strb ? $urandom : 32'hFFFF_FFFF);
      if (err == 2'b00) begin
        idx = beat_idx(start, len, burst, i);
        for (int b = 0; b < 32; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      bus.s_axi_wdata = d; bus.s_axi_wstrb = s; bus.s_axi_wlast = (i == last_at);
      bus.s_axi_wvalid = 1'b1;
      wait_hs(1, ok);
      bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
    end
  endtask

  task automatic do_read(input logic [5:0] id, input logic [63:0] addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size);
    logic [1:0] err;
    int start;
    bit ok;
    err = model_err(addr, len, burst, size);
    start = int'(addr[10:5]);
    for (int i = 0; i <= len; i++)
      r_q.push_back('{id: id, data: (err != 2'b00) ? 256'd0 : mdl[beat_idx(start, len, burst, i)],
                      resp: err, last: (i == len)});
    bus.s_axi_arid = id; bus.s_axi_araddr = addr; bus.s_axi_arlen = 8'(len);
    bus.s_axi_arsize = size; bus.s_axi_arburst = burst; bus.s_axi_arvalid = 1'b1;
    wait_hs(2, ok);
    bus.s_axi_arvalid = 1'b0;
    if (ok) check("ar_to_r_latency", 256'(bus.s_axi_rvalid), 256'd1);
  endtask

  always @(posedge clk) begin
    #1;
    bus.s_axi_bready = ($urandom_range(0, 3) != 0);
    case (rready_mode)
      0: bus.s_axi_rready = ($urandom_range(0, 3) != 0);
      1: bus.s_axi_rready = 1'b0;
      default: bus.s_axi_rready = 1'b1;
    endcase
  end

  // Monitor: each B/R handshake pops the oldest expectation.
  always @(negedge clk) begin
    b_exp_t be;
    r_exp_t re;
    if (rst_n) begin
      if (bus.s_axi_bvalid && bus.s_axi_bready) begin
        if (b_q.size() == 0) fail_now("unexpected_b");
        else begin
          be = b_q.pop_front();
          check("bid", 256'(bus.s_axi_bid), 256'(be.id));
          check("bresp", 256'(bus.s_axi_bresp), 256'(be.resp));
        end
      end
      if (bus.s_axi_rvalid && bus.s_axi_rready) begin
        if (r_q.size() == 0) fail_now("unexpected_r");
        else begin
          re = r_q.pop_front();
          check("rid", 256'(bus.s_axi_rid), 256'(re.id));
          check("rdata", bus.s_axi_rdata, re.data);
          check("rresp", 256'(bus.s_axi_rresp), 256'(re.resp));
          check("rlast", 256'(bus.s_axi_rlast), 256'(re.last));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    int wl[4] = '{1, 3, 7, 15};
    logic [63:0] a;
    logic [1:0] bu;
    logic [2:0] sz;
    int ln;
    int la;
    bit seen;

    bus.s_axi_awvalid = 1'b0; bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0;
    bus.s_axi_awsize = '0; bus.s_axi_awburst = '0; bus.s_axi_wvalid = 1'b0; bus.s_axi_wdata = '0;
    bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_bready = 1'b0;
    bus.s_axi_arvalid = 1'b0; bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0;
    bus.s_axi_arsize = '0; bus.s_axi_arburst = '0; bus.s_axi_rready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 256'(bus.s_axi_awready), 256'd0);
    check("rst_wready", 256'(bus.s_axi_wready), 256'd0);
    check("rst_arready", 256'(bus.s_axi_arready), 256'd0);
    check("rst_bvalid", 256'(bus.s_axi_bvalid), 256'd0);
    check("rst_rvalid", 256'(bus.s_axi_rvalid), 256'd0);
    check("rst_rdata", bus.s_axi_rdata, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_awready", 256'(bus.s_axi_awready), 256'd1);
    check("post_rst_arready", 256'(bus.s_axi_arready), 256'd1);

    // Fill the whole RAM so every later readback has a defined model value.
    for (int k = 0; k < 4; k++) begin
      do_write(6'(k), 64'(k * 512), 15, 2'b01, 3'd5, 15, 1'b0, 32'hFFFF_FFFF, 1'b0);
      wait_drain();
    end

    do_write(6'h11, 64'h40, 0, 2'b01, 3'd5, 0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    wait_drain();
    do_read(6'h12, 64'h40, 0, 2'b01, 3'd5);
    wait_drain();

    do_write(6'h01, 64'h80, 3, 2'b01, 3'd5, 3, 1'b0, 32'hFFFF_FFFF, 1'b0);
    wait_drain();
    do_write(6'h02, 64'h80, 3, 2'b01, 3'd5, 3, 1'b0, 32'h0000_FFFF, 1'b0);
    wait_drain();
    do_read(6'h03, 64'h80, 3, 2'b01, 3'd5);
    wait_drain();

    do_write(6'h04, 64'h60, 3, 2'b10, 3'd5, 3, 1'b0, 32'hFFFF_FFFF, 1'b0);
    wait_drain();
    do_read(6'h05, 64'h60, 3, 2'b10, 3'd5);
    wait_drain();
    do_read(6'h06, 64'h00, 3, 2'b01, 3'd5);
    wait_drain();
    do_write(6'h07, 64'h60, 2, 2'b10, 3'd5, 2, 1'b0, 32'hFFFF_FFFF, 1'b0);
    wait_drain();
    do_read(6'h08, 64'h00, 3, 2'b01, 3'd5);
    wait_drain();

    do_write(6'h09, 64'h800, 3, 2'b01, 3'd5, 3, 1'b0, 32'hFFFF_FFFF, 1'b0);
    wait_drain();
    do_read(6'h0A, 64'h800, 3, 2'b01, 3'd5);
    wait_drain();
    do_read(6'h0B, 64'h000, 3, 2'b01, 3'd5);
    wait_drain();

    do_write(6'h15, 64'h300, 1, 2'b01, 3'd4, 1, 1'b0, 32'hFFFF_FFFF, 1'b0);
    wait_drain();
    do_write(6'h16, 64'h300, 1, 2'b11, 3'd5, 1, 1'b0, 32'hFFFF_FFFF, 1'b0);
    wait_drain();
    do_read(6'h17, 64'h300, 1, 2'b11, 3'd5);
    wait_drain();
    do_read(6'h18, 64'h300, 1, 2'b01, 3'd5);
    wait_drain();

    do_write(6'h0C, 64'h200, 3, 2'b01, 3'd5, 1, 1'b0, 32'hFFFF_FFFF, 1'b0);
    wait_drain();
    do_write(6'h0D, 64'h280, 3, 2'b01, 3'd5, 99, 1'b0, 32'hFFFF_FFFF, 1'b0);
    wait_drain();
    do_write(6'h0E, 64'h240, 0, 2'b00, 3'd5, 0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    wait_drain();
    do_read(6'h0F, 64'h200, 7, 2'b01, 3'd5);
    wait_drain();

    // Stall rready for five cycles on beat 3 of an 8-beat burst.
    rready_mode = 2;
    fork
      do_read(6'h21, 64'h0, 7, 2'b01, 3'd5);
      begin
        seen = 1'b0;
        for (int t = 0; t < 300; t++) begin
          @(posedge clk);
          if (r_q.size() == 5) begin seen = 1'b1; break; end
        end
        rready_mode = 1;
        if (!seen) fail_now("stall_setup_timeout");
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (r_q.size() == 0) fail_now("stall_queue_empty");
          else begin
            check("stall_rvalid", 256'(bus.s_axi_rvalid), 256'd1);
            check("stall_rdata", bus.s_axi_rdata, r_q[0].data);
            check("stall_rlast", 256'(bus.s_axi_rlast), 256'(r_q[0].last));
          end
        end
        rready_mode = 0;
      end
    join
    wait_drain();

    for (int t = 0; t < 60; t++) begin
      a = 64'($urandom_range(0, 2047));
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 64'h800 + 64'($urandom_range(0, 4095)) : 64'h1 << 40;
      bu = 2'($urandom_range(0, 2));
      ln = (bu == 2'b10) ? wl[$urandom_range(0, 3)] : $urandom_range(0, 15);
      sz = 3'd5;
      if ($urandom_range(0, 15) == 0) bu = 2'b11;
      if ($urandom_range(0, 15) == 0) sz = 3'd3;
      if ($urandom_range(0, 1) == 0) begin
        la = ($urandom_range(0, 9) == 0) ? $urandom_range(0, ln + 1) : ln;
        do_write(6'($urandom), a, ln, bu, sz, la, 1'b1, $urandom, 1'b0);
      end else begin
        do_read(6'($urandom), a, ln, bu, sz);
      end
      wait_drain();
    end

    // Reset while beat 2 of an 8-beat read is on the bus.
    rready_mode = 2;
    fork
      do_read(6'h31, 64'h100, 7, 2'b01, 3'd5);
      begin
        seen = 1'b0;
        for (int t = 0; t < 300; t++) begin
          @(posedge clk);
          if (r_q.size() == 6) begin seen = 1'b1; break; end
        end
        if (!seen) fail_now("reset_setup_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_rvalid", 256'(bus.s_axi_rvalid), 256'd0);
        check("mid_reset_arready", 256'(bus.s_axi_arready), 256'd0);
      end
    join
    r_q.delete();
    b_q.delete();
    rready_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rerst_arready", 256'(bus.s_axi_arready), 256'd1);
    check("rerst_awready", 256'(bus.s_axi_awready), 256'd1);
    do_read(6'h32, 64'h100, 7, 2'b01, 3'd5);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
